rtc_apb_master: RTL and testbench

//   APB3 requester that drives the RTC register file's APB completer port.

---
 rtl/rtc_apb_master_pkg.sv | 31 +++
 rtl/rtc_apb_master_if.sv | 26 ++
 rtl/rtc_apb_master.sv | 156 +++++++++++++++
 tb/tb_rtc_apb_master.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rtc_apb_master_pkg.sv
// Shared types for the RTC APB requester: FSM states, latched command and response payload.
package rtc_apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

  // Only word-aligned accesses reach the register file.
  function automatic logic addr_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/rtc_apb_master_if.sv
// APB3 bus between the RTC requester (master) and the register file completer (slave).
interface rtc_apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/rtc_apb_master.sv
// APB3 requester: one APB transfer per accepted command, result returned on a valid/ready channel.
// All outputs are registers loaded from the next-state logic, so they change on the same edge as the FSM.
module rtc_apb_master
  import rtc_apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic              busy_o,
  rtc_apb_master_if.master  apb
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  apb_mst_state_e   state_r, state_s;
  apb_req_t         bus_r, bus_s;
  apb_rsp_t         rsp_r, rsp_s;
  logic [CNT_W-1:0] wait_cnt_r, wait_cnt_s, cnt_inc_s;
  logic             psel_r, psel_s;
  logic             penable_r, penable_s;
  logic             req_ready_r, req_ready_s;
  logic             rsp_valid_r, rsp_valid_s;
  logic             busy_r, busy_s;

  // Next-state, next-output and wait-counter logic.
  always_comb begin
    state_s     = state_r;
    bus_s       = bus_r;
    rsp_s       = rsp_r;
    wait_cnt_s  = wait_cnt_r;
    psel_s      = 1'b0;
    penable_s   = 1'b0;
    rsp_valid_s = 1'b0;
    cnt_inc_s   = (wait_cnt_r == CNT_MAX) ? wait_cnt_r : wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

    case (state_r)
      IDLE: begin
        if (req_valid_i && req_ready_r) begin
          if (addr_misaligned(req_addr_i[1:0])) begin
            // Rejected locally; the bus keeps its previous values.
            state_s       = RESP;
            rsp_s.rdata   = '0;
            rsp_s.err     = 1'b1;
            rsp_s.timeout = 1'b0;
            rsp_valid_s   = 1'b1;
          end else begin
            state_s     = SETUP;
            psel_s      = 1'b1;
            bus_s.write = req_write_i;
            bus_s.addr  = req_addr_i;
            bus_s.wdata = req_write_i ? req_wdata_i : '0;
            wait_cnt_s  = '0;
          end
        end else begin
          state_s = IDLE;
        end
      end

      SETUP: begin
        state_s   = ACCESS;
        psel_s    = 1'b1;
        penable_s = 1'b1;
      end

      ACCESS: begin
        if (apb.PREADY) begin
          state_s       = RESP;
          rsp_s.err     = apb.PSLVERR;
          rsp_s.timeout = 1'b0;
          rsp_s.rdata   = (!bus_r.write && !apb.PSLVERR) ? apb.PRDATA : '0;
          rsp_valid_s   = 1'b1;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc_s == CNT_LIMIT)) begin
          // Hung completer: drop the transfer mid-ACCESS.
          state_s       = RESP;
          rsp_s.err     = 1'b1;
          rsp_s.timeout = 1'b1;
          rsp_s.rdata   = '0;
          rsp_valid_s   = 1'b1;
          wait_cnt_s    = cnt_inc_s;
        end else begin
          psel_s     = 1'b1;
          penable_s  = 1'b1;
          wait_cnt_s = cnt_inc_s;
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          state_s = IDLE;
        end else begin
          rsp_valid_s = 1'b1;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    req_ready_s = (state_s == IDLE);
    busy_s      = (state_s != IDLE);
  end

  // State and output registers; reset drops the bus and any pending response at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      bus_r       <= '0;
      rsp_r       <= '0;
      wait_cnt_r  <= '0;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      bus_r       <= bus_s;
      rsp_r       <= rsp_s;
      wait_cnt_r  <= wait_cnt_s;
      psel_r      <= psel_s;
      penable_r   <= penable_s;
      req_ready_r <= req_ready_s;
      rsp_valid_r <= rsp_valid_s;
      busy_r      <= busy_s;
    end
  end

  assign req_ready_o   = req_ready_r;
  assign rsp_valid_o   = rsp_valid_r;
  assign rsp_rdata_o   = rsp_r.rdata;
  assign rsp_err_o     = rsp_r.err;
  assign rsp_timeout_o = rsp_r.timeout;
  assign busy_o        = busy_r;
  assign apb.PSEL      = psel_r;
  assign apb.PENABLE   = penable_r;
  assign apb.PWRITE    = bus_r.write;
  assign apb.PADDR     = bus_r.addr;
  assign apb.PWDATA    = bus_r.wdata;

endmodule

// File: tb/tb_rtc_apb_master.sv
// Directed bench for rtc_apb_master: hand-computed expectations, APB completer modelled by bench-driven signals.
module tb_rtc_apb_master;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_write_i = 1'b0;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;
  int pen;

  rtc_apb_master_if #(.ADDR_W(32), .DATA_W(32)) apb ();

  rtc_apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_write_i   (req_write_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_err_o     (rsp_err_o),
    .rsp_timeout_o (rsp_timeout_o),
    .busy_o        (busy_o),
    .apb           (apb.master)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    tick();
    req_valid_i = 1'b0;
  endtask

  initial begin
    apb.PRDATA  = 32'h0;
    apb.PREADY  = 1'b1;
    apb.PSLVERR = 1'b0;

    // Reset state
    tick();
    tick();
    check_eq("rst_ctl", {req_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, busy_o,
                         apb.PSEL, apb.PENABLE, apb.PWRITE}, 64'h0);
    check_eq("rst_bus", {apb.PADDR, apb.PWDATA}, 64'h0);
    check_eq("rst_rdata", rsp_rdata_o, 64'h0);
    rst_i = 1'b0;
    tick();
    check_eq("idle_ready", {req_ready_o, busy_o}, 64'h2);

    // 1: write 0x04 <- 1, zero wait states
    send(1'b1, 32'h4, 32'h1);
    check_eq("t1_setup", {apb.PSEL, apb.PENABLE, apb.PWRITE, req_ready_o, busy_o}, 64'b10101);
    check_eq("t1_bus", {apb.PADDR, apb.PWDATA}, {32'h4, 32'h1});
    tick();
    check_eq("t1_access", {apb.PSEL, apb.PENABLE, rsp_valid_o}, 64'b110);
    tick();
    check_eq("t1_rsp", {rsp_valid_o, rsp_err_o, rsp_timeout_o, apb.PSEL, apb.PENABLE}, 64'b10000);
    check_eq("t1_rdata", rsp_rdata_o, 64'h0);
    tick();
    check_eq("t1_back_idle", {rsp_valid_o, req_ready_o, busy_o}, 64'b010);

    // 2: read 0x10 with 3 wait states
    apb.PREADY = 1'b0;
    apb.PRDATA = 32'h0000_002A;
    send(1'b0, 32'h10, 32'hFFFF_FFFF);
    check_eq("t2_setup", {apb.PSEL, apb.PENABLE, apb.PWRITE}, 64'b100);
    check_eq("t2_pwdata", apb.PWDATA, 64'h0);
    pen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (apb.PENABLE) begin
        pen++;
        check_eq("t2_paddr", apb.PADDR, 64'h10);
      end
      if (pen == 4) apb.PREADY = 1'b1;
      if (rsp_valid_o) break;
    end
    check_eq("t2_pen_cycles", pen, 64'd4);
    check_eq("t2_rsp", {rsp_valid_o, rsp_err_o, rsp_timeout_o}, 64'b100);
    check_eq("t2_rdata", rsp_rdata_o, 64'h2A);
    tick();

    // 3: read 0x08 answered with PSLVERR
    apb.PSLVERR = 1'b1;
    apb.PRDATA  = 32'hDEAD_BEEF;
    send(1'b0, 32'h8, 32'h0);
    tick();
    tick();
    check_eq("t3_rsp", {rsp_valid_o, rsp_err_o, rsp_timeout_o}, 64'b110);
    check_eq("t3_rdata", rsp_rdata_o, 64'h0);
    tick();
    apb.PSLVERR = 1'b0;

    // 4: completer hangs, timeout after 16 ACCESS cycles
    apb.PREADY = 1'b0;
    send(1'b1, 32'hC, 32'h1234_5678);
    pen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (apb.PENABLE) pen++;
      if (rsp_valid_o) break;
    end
    check_eq("t4_pen_cycles", pen, 64'd16);
    check_eq("t4_rsp", {rsp_valid_o, rsp_err_o, rsp_timeout_o, apb.PSEL}, 64'b1110);
    check_eq("t4_rdata", rsp_rdata_o, 64'h0);
    tick();

    // 5: misaligned request never reaches the bus
    apb.PREADY = 1'b1;
    send(1'b0, 32'h6, 32'h0);
    check_eq("t5_rsp", {rsp_valid_o, rsp_err_o, rsp_timeout_o, apb.PSEL}, 64'b1100);
    check_eq("t5_paddr_kept", apb.PADDR, 64'hC);
    tick();
    check_eq("t5_idle", {rsp_valid_o, req_ready_o, apb.PSEL}, 64'b010);

    // 6: response back-pressure, then reset during the next ACCESS
    apb.PRDATA  = 32'h0000_0055;
    rsp_ready_i = 1'b0;
    send(1'b0, 32'h14, 32'h0);
    tick();
    tick();
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i  = 32'h18;
    for (int i = 0; i < 5; i++) begin
      check_eq("t6_hold", {rsp_valid_o, rsp_err_o, req_ready_o, apb.PSEL}, 64'b1000);
      check_eq("t6_hold_rdata", rsp_rdata_o, 64'h55);
      tick();
    end
    check_eq("t6_no_accept", apb.PADDR, 64'h14);
    apb.PREADY  = 1'b0;
    rsp_ready_i = 1'b1;
    tick();
    check_eq("t6_released", {rsp_valid_o, req_ready_o}, 64'b01);
    tick();
    req_valid_i = 1'b0;
    tick();
    check_eq("t6_access", {apb.PSEL, apb.PENABLE}, 64'b11);
    check_eq("t6_paddr", apb.PADDR, 64'h18);
    rst_i = 1'b1;
    #1;
    check_eq("t6_rst_ctl", {req_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, busy_o,
                            apb.PSEL, apb.PENABLE, apb.PWRITE}, 64'h0);
    check_eq("t6_rst_bus", {apb.PADDR, apb.PWDATA}, 64'h0);
    tick();
    rst_i = 1'b0;
    tick();
    check_eq("t6_idle", {req_ready_o, busy_o, rsp_valid_o}, 64'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
